dbg_bus_bridge: RTL and testbench

DBG_BUS_BRIDGE -- requirements
Module: dbg_bus_bridge

---
 rtl/dbg_bus_bridge.sv | 184 ++++++++++++++++++
 tb/tb_dbg_bus_bridge.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/dbg_bus_bridge.sv
// dbg_bus_bridge: byte-command stream to single-beat bus initiator.
// Frame: cmd byte {write, 00000, hb}, 4 address bytes (LSB first),
// 4 write-data bytes when write. Response bytes stream out on tx_*.
// Optional macro DBG_BUS_BRIDGE_TIMEOUT_EN adds a grant-wait timeout.
module dbg_bus_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [7:0]  ACK_BYTE       = 8'hA5
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        rx_valid_i,
    input  logic [7:0]  rx_data_i,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic        bus_req_o,
    input  logic        bus_gnt_i,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    output logic        bus_we_o,
    output logic        bus_re_o,
    output logic [1:0]  bus_hb_o,
    output logic [7:0]  bus_ce_o,
    input  logic [31:0] bus_rdata_i,
    output logic        busy_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_BUS,
        S_RESP
    } state_t;

    localparam logic [7:0] BAD_CMD_BYTE = 8'hEF;

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;        // byte index within ADDR/DATA/RESP
    logic        write_q, write_d;
    logic [1:0]  hb_q, hb_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] resp_q, resp_d;      // response bytes, LSB sent first
    logic [1:0]  last_q, last_d;      // index of final response byte

`ifdef DBG_BUS_BRIDGE_TIMEOUT_EN
    localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYCLES);
    localparam logic [7:0] TMO_BYTE  = 8'hEE;
    logic [7:0]  tmo_q, tmo_d;
`endif

    // State register and datapath flops, all cleared asynchronously.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            write_q <= 1'b0;
            hb_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            resp_q  <= '0;
            last_q  <= '0;
`ifdef DBG_BUS_BRIDGE_TIMEOUT_EN
            tmo_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            hb_q    <= hb_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            resp_q  <= resp_d;
            last_q  <= last_d;
`ifdef DBG_BUS_BRIDGE_TIMEOUT_EN
            tmo_q   <= tmo_d;
`endif
        end
    end

    // Next-state logic: frame parsing, bus handshake, response streaming.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        hb_d    = hb_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        resp_d  = resp_q;
        last_d  = last_q;
`ifdef DBG_BUS_BRIDGE_TIMEOUT_EN
        tmo_d   = '0;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (rx_valid_i) begin
                    cnt_d = '0;
                    if (rx_data_i[6:2] != 5'd0) begin
                        resp_d  = {24'h0, BAD_CMD_BYTE};
                        last_d  = 2'd0;
                        state_d = S_RESP;
                    end else begin
                        write_d = rx_data_i[7];
                        hb_d    = rx_data_i[1:0];
                        state_d = S_ADDR;
                    end
                end
            end
            S_ADDR: begin
                if (rx_valid_i) begin
                    addr_d[{cnt_q, 3'b000} +: 8] = rx_data_i;
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        cnt_d   = '0;
                        state_d = write_q ? S_DATA : S_BUS;
                    end
                end
            end
            S_DATA: begin
                if (rx_valid_i) begin
                    wdata_d[{cnt_q, 3'b000} +: 8] = rx_data_i;
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        cnt_d   = '0;
                        state_d = S_BUS;
                    end
                end
            end
            S_BUS: begin
                // Grant takes priority over a coincident timeout.
                if (bus_gnt_i) begin
                    cnt_d   = '0;
                    state_d = S_RESP;
                    if (write_q) begin
                        resp_d = {24'h0, ACK_BYTE};
                        last_d = 2'd0;
                    end else begin
                        resp_d = bus_rdata_i;
                        last_d = 2'd3;
                    end
                end
`ifdef DBG_BUS_BRIDGE_TIMEOUT_EN
                else if (tmo_q + 8'd1 == TMO_LIMIT) begin
                    cnt_d   = '0;
                    resp_d  = {24'h0, TMO_BYTE};
                    last_d  = 2'd0;
                    state_d = S_RESP;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
`endif
            end
            S_RESP: begin
                if (tx_ready_i) begin
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == last_q) begin
                        cnt_d   = '0;
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs decode from registered state so reset clears them at once.
    always_comb begin
        bus_req_o   = (state_q == S_BUS);
        bus_we_o    = bus_req_o & write_q;
        bus_re_o    = bus_req_o & ~write_q;
        bus_ce_o    = bus_req_o ? (8'd1 << addr_q[30:28]) : 8'd0;
        bus_hb_o    = hb_q;
        bus_addr_o  = addr_q;
        bus_wdata_o = wdata_q;
        tx_valid_o  = (state_q == S_RESP);
        tx_data_o   = resp_q[{cnt_q, 3'b000} +: 8];
        busy_o      = (state_q != S_IDLE);
    end

endmodule

// File: tb/tb_dbg_bus_bridge.sv
// Self-checking bench for dbg_bus_bridge: response bytes are queued as
// expectations when a frame is driven and compared as tx handshakes occur.
module tb_dbg_bus_bridge;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = '0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic        bus_req;
    logic        bus_gnt = 1'b0;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_we;
    logic        bus_re;
    logic [1:0]  bus_hb;
    logic [7:0]  bus_ce;
    logic [31:0] bus_rdata = '0;
    logic        busy;

    int pass_cnt = 0;
    int chk_cnt  = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    dbg_bus_bridge #(.TIMEOUT_CYCLES(4), .ACK_BYTE(8'hA5)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .rx_valid_i(rx_valid), .rx_data_i(rx_data),
        .tx_data_o(tx_data), .tx_valid_o(tx_valid), .tx_ready_i(tx_ready),
        .bus_req_o(bus_req), .bus_gnt_i(bus_gnt),
        .bus_addr_o(bus_addr), .bus_wdata_o(bus_wdata),
        .bus_we_o(bus_we), .bus_re_o(bus_re), .bus_hb_o(bus_hb),
        .bus_ce_o(bus_ce), .bus_rdata_i(bus_rdata), .busy_o(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    // Scoreboard consumer: every accepted response byte must match.
    always @(negedge clk) begin
        if (rst_n && tx_valid && tx_ready) begin
            if (exp_q.size() == 0) chk("tx_extra", {24'h0, tx_data}, 32'hFFFF_FFFF);
            else chk("tx_byte", {24'h0, tx_data}, {24'h0, exp_q.pop_front()});
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1; rx_data = b;
        step();
        rx_valid = 1'b0; rx_data = '0;
    endtask

    task automatic send_frame(input logic [7:0] cmd, input logic [31:0] a, input logic [31:0] d);
        send(cmd);
        for (int i = 0; i < 4; i++) send(a[i*8 +: 8]);
        if (cmd[7]) for (int i = 0; i < 4; i++) send(d[i*8 +: 8]);
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) exp_q.push_back(w[i*8 +: 8]);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((busy || exp_q.size() != 0) && n < 200) begin step(); n++; end
        chk({tag, "_idle"}, {31'h0, busy}, 32'h0);
        chk({tag, "_drained"}, exp_q.size(), 32'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // Reset state
        #12;
        chk("rst_req",  {31'h0, bus_req}, 0);
        chk("rst_ce",   {24'h0, bus_ce}, 0);
        chk("rst_txv",  {31'h0, tx_valid}, 0);
        chk("rst_busy", {31'h0, busy}, 0);
        chk("rst_addr", bus_addr, 0);
        step(); rst_n = 1'b1; step();

        // Write frame, grant three cycles after request
        send_frame(8'h82, 32'h1000_0000, 32'hDEAD_BEEF);
        chk("wr_req",   {31'h0, bus_req}, 1);
        chk("wr_we",    {31'h0, bus_we}, 1);
        chk("wr_re",    {31'h0, bus_re}, 0);
        chk("wr_addr",  bus_addr, 32'h1000_0000);
        chk("wr_ce",    {24'h0, bus_ce}, 32'h02);
        chk("wr_hb",    {30'h0, bus_hb}, 2);
        chk("wr_wdata", bus_wdata, 32'hDEAD_BEEF);
        exp_q.push_back(8'hA5);
        repeat (3) step();
        chk("wr_req_hold", {31'h0, bus_req}, 1);
        chk("wr_addr_hold", bus_addr, 32'h1000_0000);
        bus_gnt = 1'b1; step(); bus_gnt = 1'b0;
        chk("wr_req_drop", {31'h0, bus_req}, 0);
        wait_idle("wr");

        // Read frame, grant held high early (ignored until BUS), stalled tx
        tx_ready = 1'b0; bus_gnt = 1'b1; bus_rdata = 32'h1234_5678;
        send_frame(8'h02, 32'h0000_0004, 32'h0);
        chk("rd_req", {31'h0, bus_req}, 1);
        chk("rd_re",  {31'h0, bus_re}, 1);
        chk("rd_we",  {31'h0, bus_we}, 0);
        chk("rd_ce",  {24'h0, bus_ce}, 32'h01);
        push_word(32'h1234_5678);
        step(); bus_gnt = 1'b0; bus_rdata = '0;
        chk("rd_req_drop", {31'h0, bus_req}, 0);
        for (int i = 0; i < 5; i++) begin
            chk("rd_stall", {23'h0, tx_valid, tx_data}, 32'h178);
            step();
        end
        tx_ready = 1'b1;
        wait_idle("rd");

        // Bad command, then a normal byte-sized write to chip 7
        exp_q.push_back(8'hEF);
        send(8'h40);
        wait_idle("bad");
        send_frame(8'h80, 32'h7000_0001, 32'h0000_00C3);
        chk("wr2_ce",    {24'h0, bus_ce}, 32'h80);
        chk("wr2_hb",    {30'h0, bus_hb}, 0);
        chk("wr2_wdata", bus_wdata, 32'h0000_00C3);
        exp_q.push_back(8'hA5);
        bus_gnt = 1'b1; step(); bus_gnt = 1'b0;
        wait_idle("wr2");

        // Grant timeout
        n = 0;
`ifdef DBG_BUS_BRIDGE_TIMEOUT_EN
        exp_q.push_back(8'hEE);
        send_frame(8'h02, 32'h2000_0000, 32'h0);
        while (bus_req && n < 20) begin step(); n++; end
        chk("tmo_len", n, 4);
        wait_idle("tmo");
        send_frame(8'h02, 32'h3000_0000, 32'h0);
        repeat (2) step();
`else
        send_frame(8'h02, 32'h2000_0000, 32'h0);
        for (int i = 0; i < 1000; i++) begin
            if (bus_req) n++;
            step();
        end
        chk("no_tmo", n, 1000);
`endif

        // Asynchronous reset while in BUS
        chk("rst_pre_req", {31'h0, bus_req}, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_req",  {31'h0, bus_req}, 0);
        chk("arst_en",   {29'h0, bus_re, bus_we, |bus_ce}, 0);
        chk("arst_busy", {31'h0, busy}, 0);
        chk("arst_addr", bus_addr, 0);
        chk("arst_tx",   {23'h0, tx_valid, tx_data}, 0);
        step(); rst_n = 1'b1;

        // Read after reset; rx strobes during stalled RESP are dropped
        tx_ready = 1'b0; bus_gnt = 1'b1; bus_rdata = 32'hCAFE_0102;
        send_frame(8'h02, 32'h0000_0008, 32'h0);
        chk("rd2_addr", bus_addr, 32'h0000_0008);
        push_word(32'hCAFE_0102);
        step(); bus_gnt = 1'b0; bus_rdata = '0;
        send(8'h82); send(8'h00); send(8'h40);
        chk("rd2_resp_busy", {23'h0, tx_valid, tx_data}, 32'h102);
        tx_ready = 1'b1;
        wait_idle("rd2");

        // Follow-up read confirms the parser restarted at a frame start
        bus_gnt = 1'b1; bus_rdata = 32'h0BAD_F00D;
        send_frame(8'h01, 32'h5000_0010, 32'h0);
        chk("rd3_ce", {24'h0, bus_ce}, 32'h20);
        chk("rd3_hb", {30'h0, bus_hb}, 1);
        push_word(32'h0BAD_F00D);
        step(); bus_gnt = 1'b0;
        wait_idle("rd3");

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
